uart_bus_bridge: RTL
====================

// Module: uart_bus_bridge
// PURPOSE
//   Upstream master for the memory-mapped bus slaves (2 KB RAM at 0x0000-0x07FF, etc.).
//   Parses command frames from the UART receiver byte stream and drives Cmd/RW/Addr/WData.
//   Waits for the slave's Finish pulse, then returns one response byte to the UART transmitter.
//   Frames: 'R'(0x52) AH AL -> reply RData; 'W'(0x57) AH AL D -> reply ACK_BYTE.
// PARAMETERS
//   BUS_TIMEOUT  255      max cycles Cmd held without Finish before abort (8-bit counter)
//   RX_GAP       50000    max idle cycles between bytes of one frame before resync (16-bit)
//   ACK_BYTE     8'h4B    reply to a completed write ('K')
//   ERR_BYTE     8'h45    reply to bad opcode or bus timeout ('E')
// PORTS
//   clk       in   1   system clock, all logic on posedge
//   rst       in   1   asynchronous reset, active-high
//   rx_data   in   8   received byte, valid while rx_valid=1
//   rx_valid  in   1   one-cycle pulse per received byte
//   tx_data   out  8   response byte, held stable from tx_start until tx_busy falls
//   tx_start  out  1   one-cycle pulse: transmitter loads tx_data
//   tx_busy   in   1   transmitter busy; tx_start issued only when 0
//   Addr      out  16  bus address {AH,AL}
//   WData     out  8   bus write data
//   RData     in   8   bus read data, sampled in the cycle Finish=1
//   Cmd       out  1   bus request level, registered
//   RW        out  1   1=write, 0=read, stable while Cmd=1
//   Finish    in   1   slave completion pulse (one cycle)
//   busy      out  1   1 in any state other than S_OP
// BEHAVIOUR
//   Reset (async): state=S_OP; Cmd=0, RW=0, Addr=0, WData=0, tx_data=0, tx_start=0; counters=0.
//   States / transitions (rx_valid consumed only in S_OP/S_AH/S_AL/S_WD):
//   - S_OP: rx 0x52 -> RW=0, S_AH; rx 0x57 -> RW=1, S_AH; other byte -> tx_data=ERR_BYTE, S_RESP.
//   - S_AH: rx -> Addr[15:8]; S_AL.
//   - S_AL: rx -> Addr[7:0]; RW=0: Cmd<=1, S_BUS; RW=1: S_WD.
//   - S_WD: rx -> WData; Cmd<=1; S_BUS.
//   - S_AH/S_AL/S_WD: gap counter clears on each rx_valid; reaching RX_GAP-1 -> S_OP, frame dropped, no reply.
//   - S_BUS: Cmd held 1; on Finish=1: Cmd<=0 on that same edge (prevents slave re-trigger),
//     tx_data<=RData (read) or ACK_BYTE (write), S_RESP.
//     Timeout counter counts S_BUS cycles; at BUS_TIMEOUT without Finish: Cmd<=0, tx_data=ERR_BYTE, S_RESP.
//     Finish arriving in the same cycle as timeout wins (normal reply).
//   - S_RESP: when tx_busy=0 -> tx_start<=1 for exactly one cycle, S_OP.
//   Cycle timing, read to 0x0000-area slave: Cmd rises edge after AL byte; slave Finish 1 cycle later;
//   Cmd falls on next edge; tx_start earliest 2 cycles after Finish (S_RESP then pulse).
//   Bytes arriving in S_BUS/S_RESP are dropped (no buffering); busy=1 lets the host pace frames.
//   Finish seen outside S_BUS is ignored. Addr/WData/RW hold last values after completion.
//   Reset mid-transaction: Cmd drops immediately (async), any partial frame discarded, no reply.
//   Addr is never range-checked here; slaves decode their own window; unmapped -> timeout -> ERR_BYTE.
// TESTING
//   1. Frame 57 00 10 A5 to RAM -> Cmd=1,RW=1,Addr=0x0010,WData=0xA5 for 2 cycles; reply 0x4B once.
//   2. Frame 52 00 10 after test 1 -> Cmd 2 cycles, RW=0; tx_data=0xA5 with single tx_start pulse.
//   3. Frame 52 40 00 (no slave answers) -> Cmd high BUS_TIMEOUT cycles, then Cmd=0; reply 0x45.
//   4. Single byte 0x33 -> no Cmd; reply 0x45; next valid frame processed normally.
//   5. Bytes 52 00 then RX_GAP+10 idle cycles then 52 00 20 -> first partial dropped; one read of 0x0020.
//   6. tx_busy=1 held 100 cycles at reply time -> tx_start waits, pulses once after tx_busy falls;
//      rst asserted while Cmd=1 -> Cmd, tx_start, busy go 0 without waiting for clk.

Source files
------------

// File: rtl/uart_bus_bridge_if.sv
// Bus and UART-side signal bundle for uart_bus_bridge.
// The bridge sits on the master side: it consumes received bytes, drives the
// memory-mapped bus request, and hands response bytes to the transmitter.
// dbg_state mirrors the bridge FSM state so checkers can bind to it.
interface uart_bus_bridge_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic [15:0] Addr;
  logic [7:0]  WData;
  logic [7:0]  RData;
  logic        Cmd;
  logic        RW;
  logic        Finish;
  logic        busy;
  logic [2:0]  dbg_state;

  modport master (
    input  rx_data, rx_valid, tx_busy, RData, Finish,
    output tx_data, tx_start, Addr, WData, Cmd, RW, busy, dbg_state
  );

  modport slave (
    output rx_data, rx_valid, tx_busy, RData, Finish,
    input  tx_data, tx_start, Addr, WData, Cmd, RW, busy, dbg_state
  );
endinterface

// File: rtl/uart_bus_bridge.sv
// UART command-frame to memory-mapped bus bridge.
// Frames: 'R' AH AL -> reply read data; 'W' AH AL D -> reply ACK_BYTE.
// Bad opcode or bus timeout -> reply ERR_BYTE. A stalled frame (too long
// between bytes) is silently dropped and parsing restarts at the opcode.
//
// Handshakes: rx_valid is a one-cycle strobe qualifying rx_data, consumed only
// while parsing a frame; Cmd is a registered request level held until the
// slave's one-cycle Finish (or timeout); tx_start is a one-cycle strobe issued
// only while tx_busy=0, with tx_data stable from that strobe onward.
module uart_bus_bridge #(
  parameter int         BUS_TIMEOUT = 255,
  parameter int         RX_GAP      = 50000,
  parameter logic [7:0] ACK_BYTE    = 8'h4B,
  parameter logic [7:0] ERR_BYTE    = 8'h45
) (
  input  logic           clk,
  input  logic           rst,
  uart_bus_bridge_if.master bus
);

  typedef enum logic [2:0] {
    S_OP   = 3'd0,
    S_AH   = 3'd1,
    S_AL   = 3'd2,
    S_WD   = 3'd3,
    S_BUS  = 3'd4,
    S_RESP = 3'd5
  } state_t;

  localparam logic [7:0]  OP_READ  = 8'h52;
  localparam logic [7:0]  OP_WRITE = 8'h57;
  localparam logic [7:0]  TO_LAST  = 8'(BUS_TIMEOUT - 1);
  localparam logic [15:0] GAP_LAST = 16'(RX_GAP - 1);

  state_t      state_q, state_n;
  logic        cmd_q, cmd_n;
  logic        rw_q, rw_n;
  logic [15:0] addr_q, addr_n;
  logic [7:0]  wdata_q, wdata_n;
  logic [7:0]  resp_q, resp_n;     // pending reply, copied to tx_data at tx_start
  logic [7:0]  txd_q, txd_n;
  logic        txs_q, txs_n;
  logic [15:0] gap_q, gap_n;
  logic [7:0]  to_q, to_n;

  // State and datapath registers; reset drops Cmd and tx_start asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_OP;
      cmd_q   <= 1'b0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      resp_q  <= '0;
      txd_q   <= '0;
      txs_q   <= 1'b0;
      gap_q   <= '0;
      to_q    <= '0;
    end else begin
      state_q <= state_n;
      cmd_q   <= cmd_n;
      rw_q    <= rw_n;
      addr_q  <= addr_n;
      wdata_q <= wdata_n;
      resp_q  <= resp_n;
      txd_q   <= txd_n;
      txs_q   <= txs_n;
      gap_q   <= gap_n;
      to_q    <= to_n;
    end
  end

  // Frame parser, bus sequencer and reply issue
  always_comb begin
    state_n = state_q;
    cmd_n   = cmd_q;
    rw_n    = rw_q;
    addr_n  = addr_q;
    wdata_n = wdata_q;
    resp_n  = resp_q;
    txd_n   = txd_q;
    txs_n   = 1'b0;
    gap_n   = gap_q;
    to_n    = to_q;

    case (state_q)
      S_OP: begin
        gap_n = '0;
        to_n  = '0;
        if (bus.rx_valid) begin
          if (bus.rx_data == OP_READ) begin
            rw_n    = 1'b0;
            state_n = S_AH;
          end else if (bus.rx_data == OP_WRITE) begin
            rw_n    = 1'b1;
            state_n = S_AH;
          end else begin
            resp_n  = ERR_BYTE;
            state_n = S_RESP;
          end
        end
      end

      S_AH: begin
        if (bus.rx_valid) begin
          addr_n[15:8] = bus.rx_data;
          gap_n        = '0;
          state_n      = S_AL;
        end else if (gap_q == GAP_LAST) begin
          state_n = S_OP;
        end else begin
          gap_n = gap_q + 16'd1;
        end
      end

      S_AL: begin
        if (bus.rx_valid) begin
          addr_n[7:0] = bus.rx_data;
          gap_n       = '0;
          if (rw_q) begin
            state_n = S_WD;
          end else begin
            cmd_n   = 1'b1;
            to_n    = '0;
            state_n = S_BUS;
          end
        end else if (gap_q == GAP_LAST) begin
          state_n = S_OP;
        end else begin
          gap_n = gap_q + 16'd1;
        end
      end

      S_WD: begin
        if (bus.rx_valid) begin
          wdata_n = bus.rx_data;
          gap_n   = '0;
          cmd_n   = 1'b1;
          to_n    = '0;
          state_n = S_BUS;
        end else if (gap_q == GAP_LAST) begin
          state_n = S_OP;
        end else begin
          gap_n = gap_q + 16'd1;
        end
      end

      S_BUS: begin
        // Finish takes priority over a timeout landing in the same cycle
        if (bus.Finish) begin
          cmd_n   = 1'b0;
          resp_n  = rw_q ? ACK_BYTE : bus.RData;
          state_n = S_RESP;
        end else if (to_q == TO_LAST) begin
          cmd_n   = 1'b0;
          resp_n  = ERR_BYTE;
          state_n = S_RESP;
        end else begin
          to_n = to_q + 8'd1;
        end
      end

      S_RESP: begin
        if (!bus.tx_busy) begin
          txd_n   = resp_q;
          txs_n   = 1'b1;
          state_n = S_OP;
        end
      end

      default: begin
        cmd_n   = 1'b0;
        state_n = S_OP;
      end
    endcase
  end

  assign bus.Cmd       = cmd_q;
  assign bus.RW        = rw_q;
  assign bus.Addr      = addr_q;
  assign bus.WData     = wdata_q;
  assign bus.tx_data   = txd_q;
  assign bus.tx_start  = txs_q;
  assign bus.busy      = (state_q != S_OP);
  assign bus.dbg_state = state_q;

endmodule
